// File: rtl/tdc_interval.sv
// Single-shot start/stop interval TDC: coarse cycle count plus fine tap correction, result in taps.
// Result registered one cycle after the stop/timeout event; held under result_ready backpressure, extra events flagged via overrun.
module tdc_interval #(
    parameter int COARSE_W       = 16,
    parameter int TAPS_PER_CLK   = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic [5:0]            fine_count,
    input  logic                  fine_valid,
    output logic [COARSE_W+6:0]   result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  timeout,
    output logic                  busy,
    output logic                  overrun
);

    localparam int RW = COARSE_W + 7;
    localparam logic [RW-1:0]       TAPS_W = RW'(TAPS_PER_CLK);
    localparam logic [COARSE_W-1:0] TMO    = COARSE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_STOP, OUTPUT} state_t;

    state_t              state, state_nxt;
    logic [COARSE_W-1:0] coarse;
    logic [5:0]          fine_start;
    logic [RW-1:0]       stop_val;
    logic                tmo_hit;

    // k+1 edges separate the start and stop samples; the delay line advances opposite to time.
    assign stop_val = (RW'(coarse) + RW'(1)) * TAPS_W + RW'(fine_start) - RW'(fine_count);
    assign tmo_hit  = (coarse == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (arm)                  state_nxt = WAIT_START;
            WAIT_START: if (fine_valid)           state_nxt = WAIT_STOP;
            WAIT_STOP:  if (fine_valid || tmo_hit) state_nxt = OUTPUT;
            OUTPUT:     if (result_ready)         state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        result_valid = (state == OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
            coarse     <= '0;
            fine_start <= '0;
        end else begin
            overrun <= (state == OUTPUT) && fine_valid;
            case (state)
                WAIT_START: begin
                    if (fine_valid) begin
                        fine_start <= fine_count;
                        coarse     <= '0;
                    end
                end
                WAIT_STOP: begin
                    // A stop landing on the timeout cycle still yields a real measurement.
                    if (fine_valid) begin
                        result  <= stop_val;
                        timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        result  <= '1;
                        timeout <= 1'b1;
                    end else begin
                        coarse <= coarse + COARSE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tdc_interval.md
TDC_INTERVAL -- requirements
Module: tdc_interval

Interface
REQ-001 Parameter COARSE_W, default 16: width of the coarse cycle counter.
REQ-002 Parameter TAPS_PER_CLK, default 64: fine taps per clock period; power of two, at least 64.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: coarse count that aborts a measurement; at most 2^COARSE_W-1.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port arm, input, 1: request one start/stop measurement.
REQ-007 Port fine_count, input, 6: delay-line tap position from the upstream delay_line stage.
REQ-008 Port fine_valid, input, 1: fine_count is valid this cycle; marks one edge event.
REQ-009 Port result, output, COARSE_W+7: measured interval in taps.
REQ-010 Port result_valid, output, 1: result is presented.
REQ-011 Port result_ready, input, 1: downstream accepts result.
REQ-012 Port timeout, output, 1: the presented result is a timeout.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port overrun, output, 1: one-cycle pulse when an event is dropped.

Function
REQ-015 The block SHALL have four states: IDLE, WAIT_START, WAIT_STOP and OUTPUT.
REQ-016 In IDLE, arm=1 SHALL move the block to WAIT_START on the next edge; fine_valid SHALL be ignored.
REQ-017 In WAIT_START, fine_valid=1 SHALL capture fine_count as fine_start, clear the coarse counter to 0 and move to WAIT_STOP.
REQ-018 In WAIT_STOP, the coarse counter SHALL increment by 1 every cycle that fine_valid=0.
REQ-019 In WAIT_STOP, fine_valid=1 with coarse value k SHALL register result = (k+1)*TAPS_PER_CLK + fine_start - fine_stop, set timeout=0 and move to OUTPUT.
  - k+1 counts clock edges between the start and stop samples.
  - Arithmetic is unsigned at width COARSE_W+7; the result is always at least 1, so no clamp is needed.
REQ-020 In WAIT_STOP, when the coarse counter equals TIMEOUT_CYCLES and fine_valid=0, the block SHALL register result = all ones, set timeout=1 and move to OUTPUT.
REQ-021 If the stop event and the timeout occur in the same cycle, the stop event SHALL win.
REQ-022 result_valid SHALL be high exactly while in OUTPUT, so it asserts on the cycle after the stop or timeout cycle.
REQ-023 While result_valid=1, result and timeout SHALL be held stable.
REQ-024 A transfer occurs on an edge where result_valid=1 and result_ready=1; the block SHALL then go to IDLE.
REQ-025 Operation is single-shot: arm SHALL be ignored outside IDLE, including in the transfer cycle.
REQ-026 fine_valid=1 in OUTPUT SHALL be dropped and SHALL pulse overrun high for exactly that following cycle.
REQ-027 arm is sampled only in IDLE, so arm and fine_valid asserted together in IDLE SHALL NOT count the event as a start.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously enter IDLE.
REQ-029 While rst_n=0, result, result_valid, timeout, busy, overrun, the coarse counter and fine_start SHALL be 0.
REQ-030 Reset asserted mid-measurement or mid-OUTPUT SHALL abandon the measurement with no result transfer.
REQ-031 After rst_n rises, the first possible transition SHALL be IDLE to WAIT_START on arm.

Verification
REQ-032 Basic measurement: arm, start fine_count=10, stop 5 cycles later with fine_count=3 (k=4), result_ready=1 -> result=5*64+10-3=327, timeout=0, result_valid for 1 cycle.
REQ-033 Back-to-back events: start fine_count=0, stop on the next cycle with fine_count=63 -> result=1.
REQ-034 Timeout: TIMEOUT_CYCLES=20, start event, no stop -> result_valid with result all ones and timeout=1; with stop on the counter=20 cycle instead -> normal result=21*64+fine_start-fine_stop.
REQ-035 Backpressure: hold result_ready=0 for 10 cycles and inject fine_valid during that time -> result stable, overrun pulses once per event, IDLE after ready rises.
REQ-036 Reset mid-operation: drive rst_n low in WAIT_STOP -> all outputs 0 immediately; a new arm gives a correct fresh measurement.
